// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU fetch, LSU load/store) arbiter onto a
// single-ported memory. Three-state FSM (IDLE -> ACCESS -> RESP), so each
// transaction takes three cycles and the requester sees its ack in RESP.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ifu_req_i/addr_i           fetch request (read only)
//   ifu_data_o/ack_o           registered fetch data, one-cycle ack
//   lsu_req_i/we_i/addr_i/data_i  load/store request
//   lsu_data_o/ack_o           registered load data, one-cycle ack
//   mem_rd_en_o/wr_en_o/addr_o/data_o  memory command (ACCESS state only)
//   mem_data_i                 combinational read data from memory
//   busy_o                     FSM not in IDLE
module mem_arbiter #(
  parameter int PRIORITY_MODE = 0,  // 0 = round-robin, 1 = LSU always wins
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic [31:0]           ifu_data_o,
  output logic                  ifu_ack_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_data_i,
  output logic [31:0]           lsu_data_o,
  output logic                  lsu_ack_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i,
  output logic                  busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  win_q, win_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           ifu_data_q, ifu_data_d;
  logic [31:0]           lsu_data_q, lsu_data_d;

  logic any_req;
  logic grant_lsu;

  assign any_req = ifu_req_i | lsu_req_i;

  // On a tie, round-robin gives the grant to whoever did not win last time.
  always_comb begin
    grant_lsu = lsu_req_i;
    if (ifu_req_i && lsu_req_i) begin
      if (PRIORITY_MODE == 1) grant_lsu = 1'b1;
      else                    grant_lsu = (last_grant_q == ID_IFU);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ifu_data_d   = ifu_data_q;
    lsu_data_d   = lsu_data_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Snapshot the winning request; inputs are ignored until RESP.
          state_d      = S_ACCESS;
          win_d        = grant_lsu;
          last_grant_d = grant_lsu;
          addr_d       = grant_lsu ? lsu_addr_i : ifu_addr_i;
          we_d         = grant_lsu & lsu_we_i;
          wdata_d      = grant_lsu ? lsu_data_i : 32'd0;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!we_q) begin
          if (win_q == ID_LSU) lsu_data_d = mem_data_i;
          else                 ifu_data_d = mem_data_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_LSU;  // IFU wins the first tie after reset
      win_q        <= ID_IFU;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      ifu_data_q   <= 32'd0;
      lsu_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ifu_data_q   <= ifu_data_d;
      lsu_data_q   <= lsu_data_d;
    end
  end

  logic in_access;
  assign in_access = (state_q == S_ACCESS);

  assign mem_rd_en_o = in_access & ~we_q;
  assign mem_wr_en_o = in_access &  we_q;
  // Command bus is quiet outside ACCESS so stale addresses never leak out.
  assign mem_addr_o  = in_access ? addr_q  : '0;
  assign mem_data_o  = in_access ? wdata_q : 32'd0;

  assign ifu_ack_o  = (state_q == S_RESP) & (win_q == ID_IFU);
  assign lsu_ack_o  = (state_q == S_RESP) & (win_q == ID_LSU);
  assign ifu_data_o = ifu_data_q;
  assign lsu_data_o = lsu_data_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
